// File: rtl/mu0_pkg.sv
// -----------------------------------------------------------------------------
// mu0_pkg
// Shared definitions for the parametrised MU0 core: the 4-bit opcode
// enumeration, the controller state enumeration and helper functions that
// split an instruction word into opcode and operand for any address width.
//
// The helpers take the instruction zero-extended to FIELD_MAX_W bits plus the
// address width as an argument. This lets one package serve every ADDR_W
// instance without a parametrised class.
// -----------------------------------------------------------------------------
package mu0_pkg;

  // Widest instruction word the helpers handle (ADDR_W + 4 must fit).
  localparam int unsigned FIELD_MAX_W = 64;

  typedef enum logic [3:0] {
    OP_LDA = 4'd0,
    OP_STO = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_JMP = 4'd4,
    OP_JGE = 4'd5,
    OP_JNE = 4'd6,
    OP_STP = 4'd7,
    OP_OUT = 4'd8,
    OP_LDI = 4'd9
  } opcode_t;

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    MEM    = 3'd3,
    EMIT   = 3'd4,
    HALT   = 3'd5
  } state_t;

  // Opcode sits in the four bits directly above the operand field.
  function automatic logic [3:0] instr_opcode(input logic [FIELD_MAX_W-1:0] word,
                                               input int unsigned          addr_w);
    return 4'(word >> addr_w);
  endfunction

  // Operand is the low addr_w bits of the instruction word.
  function automatic logic [FIELD_MAX_W-1:0] instr_operand(input logic [FIELD_MAX_W-1:0] word,
                                                            input int unsigned          addr_w);
    logic [FIELD_MAX_W-1:0] mask;
    mask = (FIELD_MAX_W'(1) << addr_w) - FIELD_MAX_W'(1);
    return word & mask;
  endfunction

  // Opcodes 10..15 are reserved and halt the core with err set.
  function automatic logic opcode_is_legal(input logic [3:0] op);
    return op <= 4'(OP_LDI);
  endfunction

endpackage

// File: rtl/mu0_alu.sv
// -----------------------------------------------------------------------------
// mu0_alu
// Purely combinational datapath of the MU0 core.
//
// Ports:
//   acc        in   DATA_W  current accumulator
//   operand    in   DATA_W  memory read data, or zero-extended immediate (LDI)
//   op         in   4       opcode of the instruction being executed
//   acc_next   out  DATA_W  accumulator value the instruction would produce
//   jge_taken  out  1       accumulator is non-negative (two's complement)
//   jne_taken  out  1       accumulator is non-zero
//
// Arithmetic wraps modulo 2^DATA_W; no flags are kept.
// -----------------------------------------------------------------------------
module mu0_alu
  import mu0_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] acc_next,
  output logic              jge_taken,
  output logic              jne_taken
);

  always_comb begin
    // NOTE: acc_next gets a default before the case so that opcodes which
    // leave the accumulator alone cannot infer a latch.
    acc_next = acc;
    case (op)
      OP_LDA, OP_LDI: acc_next = operand;
      OP_ADD:         acc_next = acc + operand;
      OP_SUB:         acc_next = acc - operand;
      default:        acc_next = acc;
    endcase
  end

  // Signed acc >= 0 is simply a clear sign bit.
  assign jge_taken = ~acc[DATA_W-1];
  assign jne_taken = |acc;

endmodule

// File: rtl/mu0_param_core.sv
// -----------------------------------------------------------------------------
// mu0_param_core
// Multi-cycle MU0 processor with generic data/address widths, one
// request/acknowledge memory port (any number of wait states) and a
// valid/ready output channel for OUT results.
//
// Parameters:
//   DATA_W  accumulator and memory word width (must be >= ADDR_W + 4)
//   ADDR_W  program counter, operand and memory address width
//
// Ports:
//   clk        in   1       clock, rising edge
//   rst_n      in   1       synchronous active-low reset
//   mem_req    out  1       memory access request
//   mem_we     out  1       1 = write, 0 = read (valid while mem_req)
//   mem_addr   out  ADDR_W  access address
//   mem_wdata  out  DATA_W  write data, always the accumulator
//   mem_rdata  in   DATA_W  read data, sampled on the ack cycle
//   mem_ack    in   1       access complete (ignored while mem_req = 0)
//   out_valid  out  1       out_data holds an OUT result
//   out_data   out  DATA_W  accumulator value being emitted
//   out_ready  in   1       consumer accepts out_data
//   running    out  1       executing (not in BOOT or HALT)
//   err        out  1       halted on an illegal opcode
//   pc         out  ADDR_W  program counter (debug)
//   acc        out  DATA_W  accumulator (debug)
//
// Every handshake output is decoded from registered state only. While a
// request or an output is stalled, state, pc, acc and the instruction
// register are all frozen, so address, write data and out_data stay stable
// until the cycle the handshake completes.
// -----------------------------------------------------------------------------
module mu0_param_core
  import mu0_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              running,
  output logic              err,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc
);

  localparam int unsigned       INSTR_W = ADDR_W + 4;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

  state_t               state;
  logic [INSTR_W-1:0]   ir;

  logic [3:0]           op;
  logic [ADDR_W-1:0]    operand;
  logic [ADDR_W-1:0]    pc_inc;
  logic [DATA_W-1:0]    alu_operand;
  logic [DATA_W-1:0]    acc_next;
  logic                 jge_taken;
  logic                 jne_taken;
  logic                 op_legal;

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  assign op       = instr_opcode(FIELD_MAX_W'(ir), ADDR_W);
  assign operand  = ADDR_W'(instr_operand(FIELD_MAX_W'(ir), ADDR_W));
  assign op_legal = opcode_is_legal(op);

  // PC arithmetic wraps naturally at 2^ADDR_W.
  assign pc_inc = pc + PC_STEP;

  // Memory data feeds the ALU for LDA/ADD/SUB; LDI uses the zero-extended
  // operand field while still in DECODE.
  assign alu_operand = (state == MEM) ? mem_rdata : DATA_W'(operand);

  mu0_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .acc       (acc),
    .operand   (alu_operand),
    .op        (op),
    .acc_next  (acc_next),
    .jge_taken (jge_taken),
    .jne_taken (jne_taken)
  );

  // ---------------------------------------------------------------------------
  // Handshake outputs, decoded from state so they drop on the same edge that
  // reset (or a completed handshake) moves the controller on.
  // ---------------------------------------------------------------------------
  assign mem_req   = (state == FETCH) || (state == MEM);
  assign mem_we    = (state == MEM) && (op == OP_STO);
  assign mem_addr  = (state == MEM) ? operand : pc;
  assign mem_wdata = acc;

  assign out_valid = (state == EMIT);
  assign out_data  = acc;

  assign running   = (state != BOOT) && (state != HALT);

  // ---------------------------------------------------------------------------
  // Controller, PC and registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: all state here is updated with non-blocking assignments so every
    // register sees the values from before this edge, independent of order.
    if (!rst_n) begin
      // Reset outranks any ack or ready arriving on the same edge: the
      // pending access is simply abandoned.
      state <= BOOT;
      pc    <= '0;
      acc   <= '0;
      err   <= 1'b0;
      ir    <= '0;
    end else begin
      case (state)
        BOOT: state <= FETCH;

        FETCH: begin
          if (mem_ack) begin
            ir    <= mem_rdata[INSTR_W-1:0];
            state <= DECODE;
          end
        end

        DECODE: begin
          state <= FETCH;
          if (!op_legal) begin
            err   <= 1'b1;
            state <= HALT;
          end else begin
            case (op)
              OP_JMP: pc <= operand;
              OP_JGE: pc <= jge_taken ? operand : pc_inc;
              OP_JNE: pc <= jne_taken ? operand : pc_inc;
              OP_LDI: begin
                acc <= acc_next;
                pc  <= pc_inc;
              end
              OP_LDA, OP_STO, OP_ADD, OP_SUB: state <= MEM;
              OP_OUT:  state <= EMIT;
              default: state <= HALT;  // OP_STP: pc stays on the STP
            endcase
          end
        end

        MEM: begin
          if (mem_ack) begin
            // A store is committed by memory on this ack; only reads load acc.
            if (op != OP_STO) acc <= acc_next;
            pc    <= pc_inc;
            state <= FETCH;
          end
        end

        EMIT: begin
          if (out_ready) begin
            pc    <= pc_inc;
            state <= FETCH;
          end
        end

        HALT:    state <= HALT;
        default: state <= BOOT;
      endcase
    end
  end

endmodule
